// File: rtl/ms53l_frame_tx.sv
// MS53L command-frame transmitter.
// Builds header/fields/payload/checksum/CRLF and streams bytes to a UART TX.
module ms53l_frame_tx #(
  parameter int         MAX_DATA    = 4,
  parameter int         GAP_CYCLES  = 4900,
  parameter bit         APPEND_CRLF = 1'b1,
  parameter logic [7:0] HEADER      = 8'h51
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_type,
  input  logic [15:0]           cmd_addr,
  input  logic [7:0]            cmd_rw,
  input  logic [7:0]            cmd_func,
  input  logic [7:0]            cmd_len,
  input  logic [8*MAX_DATA-1:0] cmd_data,
  input  logic                  tx_busy,
  output logic                  tx_en,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int DW = 8 * MAX_DATA;
  localparam logic [4:0] CRLF_N = APPEND_CRLF ? 5'd2 : 5'd0;
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TX,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      chk_q, chk_d;
  logic [3:0]      len_q, len_d;
  logic [7:0]      type_q, type_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      rw_q, rw_d;
  logic [7:0]      func_q, func_d;
  logic [DW-1:0]   data_q, data_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            done_q, done_d;

  logic [4:0]      nbytes;
  logic [4:0]      chk_idx;
  logic [7:0]      cur_byte;
  logic [3:0]      len_eff;

  assign nbytes  = 5'd8 + {1'b0, len_q} + CRLF_N;
  assign chk_idx = 5'd7 + {1'b0, len_q};
  assign len_eff = (cmd_len > 8'(MAX_DATA)) ? 4'(MAX_DATA)
                                            : cmd_len[3:0];

  // The frame_done cycle still counts as busy so the block frees up after it.
  assign cmd_ready  = (state_q == S_IDLE) && !done_q;
  assign busy       = (state_q != S_IDLE) || done_q;
  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign frame_done = done_q;

  // Select the frame byte addressed by the current byte index.
  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      5'd0: cur_byte = HEADER;
      5'd1: cur_byte = type_q;
      5'd2: cur_byte = addr_q[15:8];
      5'd3: cur_byte = addr_q[7:0];
      5'd4: cur_byte = rw_q;
      5'd5: cur_byte = func_q;
      5'd6: cur_byte = {4'h0, len_q};
      default: begin
        if (idx_q == chk_idx) begin
          cur_byte = chk_q;
        end else if (idx_q == chk_idx + 5'd1) begin
          cur_byte = 8'h0D;
        end else if (idx_q == chk_idx + 5'd2) begin
          cur_byte = 8'h0A;
        end else begin
          for (int i = 0; i < MAX_DATA; i++) begin
            if (idx_q == 5'(7 + i)) begin
              cur_byte = data_q[8*i +: 8];
            end
          end
        end
      end
    endcase
  end

  // Next-state logic: accept, issue bytes, then hold off for the gap.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    len_d     = len_q;
    type_d    = type_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    func_d    = func_q;
    data_d    = data_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          type_d  = cmd_type;
          addr_d  = cmd_addr;
          rw_d    = cmd_rw;
          func_d  = cmd_func;
          len_d   = len_eff;
          data_d  = cmd_data;
          idx_d   = 5'd0;
          chk_d   = 8'h00;
          state_d = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (!tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = cur_byte;
          idx_d     = idx_q + 5'd1;
          cnt_d     = '0;
          if (idx_q < chk_idx) begin
            chk_d = chk_q + cur_byte;
          end
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          if (idx_q == nbytes) begin
            done_d  = 1'b1;
            idx_d   = 5'd0;
            chk_d   = 8'h00;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_TX;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 5'd0;
      cnt_q     <= '0;
      chk_q     <= 8'h00;
      len_q     <= 4'h0;
      type_q    <= 8'h00;
      addr_q    <= 16'h0000;
      rw_q      <= 8'h00;
      func_q    <= 8'h00;
      data_q    <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      len_q     <= len_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      func_q    <= func_d;
      data_q    <= data_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ms53l_frame_tx.sv
// Directed self-checking bench for ms53l_frame_tx.
// Two instances: CR/LF appended and CR/LF omitted.
module tb_ms53l_frame_tx;

  localparam int GAP = 5;
  localparam int SP  = GAP + 2;

  typedef logic [7:0] frame_t [16];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_valid2 = 1'b0;
  logic [7:0]  cmd_type = 8'h00;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_rw = 8'h00;
  logic [7:0]  cmd_func = 8'h00;
  logic [7:0]  cmd_len = 8'h00;
  logic [31:0] cmd_data = 32'h0;
  logic        tx_busy = 1'b0;

  logic        cmd_ready, tx_en, busy, frame_done;
  logic [7:0]  tx_data;
  logic        cmd_ready2, tx_en2, busy2, frame_done2;
  logic [7:0]  tx_data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done1 = 0;
  int done2 = 0;
  int done_cyc = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int t1[$];

  frame_t REF = '{8'h51, 8'h0B, 8'h00, 8'h01, 8'h00, 8'h05, 8'h02,
                  8'h00, 8'h64, 8'hC8, 8'h0D, 8'h0A,
                  8'h00, 8'h00, 8'h00, 8'h00};
  frame_t ZER = '{8'h51, 8'h0B, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00,
                  8'h62, 8'h0D, 8'h0A, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00};
  frame_t CLP = '{8'h51, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h4C, 8'h0D, 8'h0A,
                  8'h00, 8'h00};

  ms53l_frame_tx #(
    .MAX_DATA(4), .GAP_CYCLES(GAP), .APPEND_CRLF(1'b1), .HEADER(8'h51)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
    .cmd_func(cmd_func), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .busy(busy), .frame_done(frame_done)
  );

  ms53l_frame_tx #(
    .MAX_DATA(4), .GAP_CYCLES(GAP), .APPEND_CRLF(1'b0), .HEADER(8'h51)
  ) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw),
    .cmd_func(cmd_func), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .tx_busy(1'b0), .tx_en(tx_en2), .tx_data(tx_data2),
    .busy(busy2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_en) begin
      q1.push_back(tx_data);
      t1.push_back(cyc);
    end
    if (frame_done) begin
      done1++;
      done_cyc = cyc;
    end
    if (tx_en2) q2.push_back(tx_data2);
    if (frame_done2) done2++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] ty,
                      input logic [15:0] ad, input logic [7:0] rw,
                      input logic [7:0] fn, input logic [7:0] ln,
                      input logic [31:0] dt, output int t_acc);
    int n;
    n = 0;
    cmd_type = ty;
    cmd_addr = ad;
    cmd_rw   = rw;
    cmd_func = fn;
    cmd_len  = ln;
    cmd_data = dt;
    if (which == 1) cmd_valid = 1'b1;
    else cmd_valid2 = 1'b1;
    while (((which == 1) ? !cmd_ready : !cmd_ready2) && n < 100) begin
      tick();
      n++;
    end
    chk("accept_timeout", 32'(n < 100), 32'd1);
    t_acc = cyc;
    tick();
    cmd_valid  = 1'b0;
    cmd_valid2 = 1'b0;
    if (which == 1) begin
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("ready_after_accept", 32'(cmd_ready), 32'd0);
    end else begin
      chk("busy2_after_accept", 32'(busy2), 32'd1);
    end
  endtask

  task automatic wait_done(input int which, input int base);
    int n;
    n = 0;
    while (((which == 1) ? done1 : done2) == base && n < 3000) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_bytes(input int k);
    int n;
    n = 0;
    while (q1.size() < k && n < 500) begin
      tick();
      n++;
    end
    chk("bytes_timeout", 32'(n < 500), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int which,
                             input frame_t e, input int n,
                             input int skip);
    logic [31:0] got;
    int sz;
    sz = (which == 1) ? q1.size() : q2.size();
    chk($sformatf("%s_count", tag), 32'(sz), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < sz) got = (which == 1) ? {24'h0, q1[i]} : {24'h0, q2[i]};
      else got = 32'hDEAD;
      chk($sformatf("%s_b%0d", tag, i), got, {24'h0, e[i]});
    end
    if (which == 1) begin
      for (int i = 1; i < n && i < sz; i++) begin
        if (i != skip) begin
          chk($sformatf("%s_sp%0d", tag, i), 32'(t1[i] - t1[i-1]),
              32'(SP));
        end
      end
    end
    q1.delete();
    q2.delete();
    t1.delete();
  endtask

  initial begin
    int ta;
    int base;
    int rel;

    repeat (3) tick();
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    repeat (2) tick();

    base = done1;
    send(1, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'd2, 32'h0000_6400, ta);
    wait_done(1, base);
    chk("ref_first", 32'(t1.size() > 0 ? t1[0] : -1), 32'(ta + 2));
    chk("ref_done_at",
        32'(done_cyc), 32'(t1.size() == 12 ? t1[11] + GAP + 1 : -1));
    tick();
    chk("ref_busy_end", 32'(busy), 32'd0);
    chk("ref_ready_end", 32'(cmd_ready), 32'd1);
    chk("ref_done_cnt", 32'(done1), 32'(base + 1));
    check_frame("ref", 1, REF, 12, -1);

    base = done1;
    rel = done_cyc;
    send(1, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'd0, 32'h0, ta);
    chk("b2b_accept", 32'(ta), 32'(rel + 1));
    wait_done(1, base);
    check_frame("zero", 1, ZER, 10, -1);

    base = done2;
    send(2, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'd0, 32'h0, ta);
    wait_done(2, base);
    tick();
    chk("zero2_busy_end", 32'(busy2), 32'd0);
    check_frame("zero_nocrlf", 2, ZER, 8, -1);

    tick();
    base = done1;
    send(1, 8'hFF, 16'hFFFF, 8'hFF, 8'hFF, 8'd7, 32'hFFFF_FFFF, ta);
    wait_done(1, base);
    check_frame("clamp", 1, CLP, 14, -1);

    tick();
    base = done1;
    send(1, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'd2, 32'h0000_6400, ta);
    wait_bytes(2);
    tx_busy = 1'b1;
    repeat (100) tick();
    chk("busy_no_strobe", 32'(q1.size()), 32'd2);
    tx_busy = 1'b0;
    rel = cyc;
    wait_done(1, base);
    chk("busy_release", 32'(t1.size() > 2 ? t1[2] : -1), 32'(rel + 1));
    check_frame("busy", 1, REF, 12, 2);

    tick();
    base = done1;
    send(1, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'd2, 32'h0000_6400, ta);
    wait_bytes(3);
    cmd_type  = 8'hAA;
    cmd_addr  = 16'h1234;
    cmd_rw    = 8'h01;
    cmd_func  = 8'h77;
    cmd_len   = 8'd1;
    cmd_data  = 32'h0000_0099;
    cmd_valid = 1'b1;
    chk("excl_ready", 32'(cmd_ready), 32'd0);
    repeat (20) tick();
    cmd_valid = 1'b0;
    wait_done(1, base);
    check_frame("excl", 1, REF, 12, -1);
    repeat (20) tick();
    chk("excl_no_extra", 32'(done1), 32'(base + 1));

    base = done1;
    send(1, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'd2, 32'h0000_6400, ta);
    wait_bytes(4);
    rst = 1'b1;
    #1;
    chk("mid_tx_en", 32'(tx_en), 32'd0);
    chk("mid_tx_data", 32'(tx_data), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(frame_done), 32'd0);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("mid_no_done", 32'(done1), 32'(base));
    chk("mid_bytes", 32'(q1.size()), 32'd4);
    q1.delete();
    t1.delete();
    base = done1;
    send(1, 8'h0B, 16'h0001, 8'h00, 8'h05, 8'd2, 32'h0000_6400, ta);
    wait_done(1, base);
    check_frame("after_rst", 1, REF, 12, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
